pipe_mem_arbiter: RTL

- Shares one single-port memory between instruction fetch (IF) and the MEM-stage data access driven by the EX/MEM register.
- Sequences each access through a small FSM, derives byte enables from the MEM-stage byte-enable opcode, and returns read data and one-cycle acks.
- Generates the stall signals that freeze the pipeline registers while an access is outstanding.

---
 rtl/pipe_mem_arbiter_if.sv | 42 ++++
 rtl/pipe_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter_if.sv
// Pipeline/memory bundle for pipe_mem_arbiter: fetch and MEM-stage request ports, memory port, stalls.
// master = arbiter side; slave = pipeline and memory side.
interface pipe_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_read;
    logic              dm_write;
    logic [2:0]        dm_beop;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    modport master (
        input  if_req, if_addr, dm_read, dm_write, dm_beop, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_be,
               mem_addr, mem_wdata, stall_if, stall_mem, err
    );

    modport slave (
        output if_req, if_addr, dm_read, dm_write, dm_beop, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_be,
               mem_addr, mem_wdata, stall_if, stall_mem, err
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter for fetch and MEM-stage data, data has priority; 2-cycle min request-to-ack.
// Optional busy-state timeout with sticky err is enabled by defining MEM_TIMEOUT_EN.
module pipe_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input logic             clk,
    input logic             rst,
    pipe_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, DM_BUSY, IF_BUSY} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;

    logic              dm_any, ack_pend, busy, tmo, finish;
    logic [DATA_W-1:0] rsp_data;

    function automatic logic [3:0] be_of(input logic [2:0] op, input logic [1:0] a);
        case (op)
            3'b001:  be_of = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  be_of = 4'b0001 << a;
            default: be_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] wdata_of(input logic [2:0] op, input logic [DATA_W-1:0] d);
        case (op)
            3'b001:  wdata_of = {2{d[15:0]}};
            3'b010:  wdata_of = {4{d[7:0]}};
            default: wdata_of = d;
        endcase
    endfunction

    assign dm_any   = bus.dm_read | bus.dm_write;
    // Holding off grants in the ack cycle stops a requester that has not yet dropped from re-granting.
    assign ack_pend = if_ack_q | dm_ack_q;
    assign busy     = (state_q == DM_BUSY) || (state_q == IF_BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // mem_ready in the timeout cycle wins, so it masks the abort.
    assign tmo   = busy & (cnt_q == CNT_W'(TIMEOUT - 1)) & ~bus.mem_ready;
    assign cnt_d = busy ? cnt_q + CNT_W'(1) : '0;
    assign err_d = err_q | tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign tmo     = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign finish   = bus.mem_ready | tmo;
    assign rsp_data = tmo ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!ack_pend) begin
                    if (dm_any)          state_d = DM_BUSY;
                    else if (bus.if_req) state_d = IF_BUSY;
                end
            end
            DM_BUSY, IF_BUSY: if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ack_pend) begin
                    if (dm_any) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.dm_write;
                        mem_be_d    = be_of(bus.dm_beop, bus.dm_addr[1:0]);
                        mem_addr_d  = bus.dm_addr & ~ADDR_W'(3);
                        mem_wdata_d = wdata_of(bus.dm_beop, bus.dm_wdata);
                    end else if (bus.if_req) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_be_d   = 4'b1111;
                        mem_addr_d = bus.if_addr & ~ADDR_W'(3);
                    end
                end
            end
            DM_BUSY: begin
                if (finish) begin
                    mem_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = rsp_data;
                end
            end
            IF_BUSY: begin
                if (finish) begin
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = rsp_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;

    assign bus.stall_mem = dm_any & ~dm_ack_q;
    assign bus.stall_if  = bus.stall_mem | (bus.if_req & ~if_ack_q);
endmodule
